// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath control.
// Defining MIPS_CTRL_PERF_EN adds cycle_count/instr_count performance counters (width CNT_W).
module mips_multicycle_ctrl #(
    parameter int ALU_CTL_W = 4
`ifdef MIPS_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic [2:0]           state,
    output logic                 illegal
`ifdef MIPS_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     instr_count
`endif
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_LW, CL_SW, CL_BEQ, CL_J, CL_ADDI, CL_ILL
    } cls_t;

    localparam logic [ALU_CTL_W-1:0] ALU_ADD = ALU_CTL_W'(0);
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = ALU_CTL_W'(1);

    function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
        cls_t c;
        c = CL_ILL;
        case (o)
            6'd0: begin
                if (f == 6'd32 || f == 6'd34 || f == 6'd36 || f == 6'd37 || f == 6'd42)
                    c = CL_R;
            end
            6'd35:   c = CL_LW;
            6'd43:   c = CL_SW;
            6'd4:    c = CL_BEQ;
            6'd2:    c = CL_J;
            6'd8:    c = CL_ADDI;
            default: c = CL_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] funct_ctl(input logic [5:0] f);
        logic [2:0] c;
        case (f)
            6'd34:   c = 3'd1;
            6'd36:   c = 3'd2;
            6'd37:   c = 3'd3;
            6'd42:   c = 3'd4;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

    state_t     state_reg, state_next;
    logic [5:0] op_reg, funct_reg;
    cls_t       cls_port, cls_lat;

    // DECODE sees IR directly on the ports; later states use the copy taken during DECODE.
    assign cls_port = classify(op, funct);
    assign cls_lat  = classify(op_reg, funct_reg);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= ST_FETCH;
            op_reg    <= 6'd0;
            funct_reg <= 6'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_DECODE) begin
                op_reg    <= op;
                funct_reg <= funct;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_ctl    = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        // Every output is forced low while reset is held, whatever state the register holds.
        if (!reset_n) begin
            state_next = ST_FETCH;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'd1;
                        state_next = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_src_b = 2'd3;
                    if (cls_port == CL_ILL) begin
                        illegal    = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (cls_lat)
                        CL_R: begin
                            alu_src_a  = 1'b1;
                            alu_ctl    = ALU_CTL_W'(funct_ctl(funct_reg));
                            state_next = ST_WB;
                        end
                        CL_LW, CL_SW: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = 2'd2;
                            state_next = ST_MEM;
                        end
                        CL_ADDI: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = 2'd2;
                            state_next = ST_WB;
                        end
                        CL_BEQ: begin
                            alu_src_a  = 1'b1;
                            alu_ctl    = ALU_SUB;
                            pc_write   = zero;
                            pc_src     = 2'd1;
                            state_next = ST_FETCH;
                        end
                        CL_J: begin
                            pc_write   = 1'b1;
                            pc_src     = 2'd2;
                            state_next = ST_FETCH;
                        end
                        default: state_next = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (cls_lat == CL_SW);
                    if (mem_ready)
                        state_next = (cls_lat == CL_LW) ? ST_WB : ST_FETCH;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls_lat == CL_R);
                    mem_to_reg = (cls_lat == CL_LW);
                    state_next = ST_FETCH;
                end
                default: state_next = ST_FETCH;
            endcase
        end
    end

    assign state = reset_n ? state_reg : 3'd0;

`ifdef MIPS_CTRL_PERF_EN
    // Index 0 counts cycles, index 1 counts instructions retired back into FETCH.
    logic [1:0] cnt_inc;
    assign cnt_inc[0] = 1'b1;
    assign cnt_inc[1] = (state_reg == ST_EXEC || state_reg == ST_MEM || state_reg == ST_WB)
                        && (state_next == ST_FETCH);

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clock) begin
            if (!reset_n)
                cnt_reg <= '0;
            else if (cnt_inc[gi])
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cycle_count = reset_n ? g_cnt[0].cnt_reg : '0;
    assign instr_count = reset_n ? g_cnt[1].cnt_reg : '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl plus latency, reset-abort and counter sequences.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        out_t       exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic       reg_write, reg_dst, mem_to_reg;
    logic [2:0] state;
    logic       illegal;
`ifdef MIPS_CTRL_PERF_EN
    logic [3:0] cycle_count, instr_count;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    mips_multicycle_ctrl #(
        .ALU_CTL_W(4)
`ifdef MIPS_CTRL_PERF_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clock(clock), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal)
`ifdef MIPS_CTRL_PERF_EN
        ,
        .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    function automatic out_t exp_zero();
        out_t e;
        e = '0;
        return e;
    endfunction

    function automatic out_t exp_fetch(input logic rdy);
        out_t e;
        e = '0;
        e.mem_req = 1'b1;
        if (rdy) begin
            e.ir_write  = 1'b1;
            e.pc_write  = 1'b1;
            e.alu_src_b = 2'd1;
        end
        return e;
    endfunction

    function automatic out_t exp_decode(input logic ill);
        out_t e;
        e = '0;
        e.state     = 3'd1;
        e.alu_src_b = 2'd3;
        e.illegal   = ill;
        return e;
    endfunction

    function automatic out_t exp_exec(input logic a, input logic [1:0] b, input logic [3:0] ctl,
                                      input logic pcw, input logic [1:0] pcs);
        out_t e;
        e = '0;
        e.state     = 3'd2;
        e.alu_src_a = a;
        e.alu_src_b = b;
        e.alu_ctl   = ctl;
        e.pc_write  = pcw;
        e.pc_src    = pcs;
        return e;
    endfunction

    function automatic out_t exp_mem(input logic we);
        out_t e;
        e = '0;
        e.state   = 3'd3;
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        e.mem_we  = we;
        return e;
    endfunction

    function automatic out_t exp_wb(input logic rd, input logic m2r);
        out_t e;
        e = '0;
        e.state      = 3'd4;
        e.reg_write  = 1'b1;
        e.reg_dst    = rd;
        e.mem_to_reg = m2r;
        return e;
    endfunction

    function automatic out_t observe();
        out_t o;
        o = '{state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
              alu_src_b, alu_ctl, reg_write, reg_dst, mem_to_reg, illegal};
        return o;
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic rdy, input out_t e);
        vec_t v;
        v.rst_n = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic add_rtype(input logic [5:0] f, input logic [3:0] ctl);
        add(1, 6'd0, f, 0, 1, exp_fetch(1));
        add(1, 6'd0, f, 0, 1, exp_decode(0));
        add(1, 6'd0, f, 0, 1, exp_exec(1, 2'd0, ctl, 0, 2'd0));
        add(1, 6'd0, f, 0, 1, exp_wb(1, 0));
    endtask

    task automatic check_out(input string name, input out_t e);
        out_t got;
        got = observe();
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, e);
        end else begin
            $display("%s ok (%h)", name, got);
        end
    endtask

    task automatic check_int(input string name, input int got, input int e);
        n_vec++;
        if (got != e) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, e);
        end else begin
            $display("%s ok (%0d)", name, got);
        end
    endtask

    // Count edges from a fresh FETCH until the FSM returns to FETCH, with memory always ready.
    task automatic measure(input string name, input logic [5:0] o, input logic [5:0] f, input int e);
        int cnt;
        reset_n = 1'b0; op = o; funct = f; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        cnt = 0;
        do begin
            @(posedge clock); #1;
            cnt++;
        end while (state != 3'd0 && cnt < 20);
        check_int(name, cnt, e);
    endtask

    initial begin
        // reset, then add with op/funct ports disturbed after DECODE
        add(0, 6'd0, 6'd0, 0, 1, exp_zero());
        add(0, 6'd0, 6'd0, 0, 1, exp_zero());
        add(1, 6'd0, 6'd32, 0, 1, exp_fetch(1));
        add(1, 6'd0, 6'd32, 0, 1, exp_decode(0));
        add(1, 6'd35, 6'd0, 0, 1, exp_exec(1, 2'd0, 4'd0, 0, 2'd0));
        add(1, 6'd35, 6'd0, 0, 1, exp_wb(1, 0));
        add_rtype(6'd34, 4'd1);
        add_rtype(6'd36, 4'd2);
        add_rtype(6'd37, 4'd3);
        add_rtype(6'd42, 4'd4);
        // addi
        add(1, 6'd8, 6'd0, 0, 1, exp_fetch(1));
        add(1, 6'd8, 6'd0, 0, 1, exp_decode(0));
        add(1, 6'd8, 6'd0, 0, 1, exp_exec(1, 2'd2, 4'd0, 0, 2'd0));
        add(1, 6'd8, 6'd0, 0, 1, exp_wb(0, 0));
        // fetch stall, then lw with 3 stall cycles in MEM
        add(1, 6'd35, 6'd0, 0, 0, exp_fetch(0));
        add(1, 6'd35, 6'd0, 0, 0, exp_fetch(0));
        add(1, 6'd35, 6'd0, 0, 1, exp_fetch(1));
        add(1, 6'd35, 6'd0, 0, 1, exp_decode(0));
        add(1, 6'd35, 6'd0, 0, 1, exp_exec(1, 2'd2, 4'd0, 0, 2'd0));
        add(1, 6'd43, 6'd0, 0, 0, exp_mem(0));
        add(1, 6'd43, 6'd0, 0, 0, exp_mem(0));
        add(1, 6'd43, 6'd0, 0, 0, exp_mem(0));
        add(1, 6'd43, 6'd0, 0, 1, exp_mem(0));
        add(1, 6'd0, 6'd32, 0, 1, exp_wb(0, 1));
        // sw
        add(1, 6'd43, 6'd0, 0, 1, exp_fetch(1));
        add(1, 6'd43, 6'd0, 0, 1, exp_decode(0));
        add(1, 6'd43, 6'd0, 0, 1, exp_exec(1, 2'd2, 4'd0, 0, 2'd0));
        add(1, 6'd43, 6'd0, 0, 1, exp_mem(1));
        // beq taken, beq not taken, j
        add(1, 6'd4, 6'd0, 0, 1, exp_fetch(1));
        add(1, 6'd4, 6'd0, 0, 1, exp_decode(0));
        add(1, 6'd4, 6'd0, 1, 1, exp_exec(1, 2'd0, 4'd1, 1, 2'd1));
        add(1, 6'd4, 6'd0, 0, 1, exp_fetch(1));
        add(1, 6'd4, 6'd0, 0, 1, exp_decode(0));
        add(1, 6'd4, 6'd0, 0, 1, exp_exec(1, 2'd0, 4'd1, 0, 2'd1));
        add(1, 6'd2, 6'd0, 0, 1, exp_fetch(1));
        add(1, 6'd2, 6'd0, 0, 1, exp_decode(0));
        add(1, 6'd2, 6'd0, 0, 1, exp_exec(0, 2'd0, 4'd0, 1, 2'd2));
        // illegal op 63, illegal funct 7
        add(1, 6'd63, 6'd0, 0, 1, exp_fetch(1));
        add(1, 6'd63, 6'd0, 0, 1, exp_decode(1));
        add(1, 6'd0, 6'd7, 0, 1, exp_fetch(1));
        add(1, 6'd0, 6'd7, 0, 1, exp_decode(1));
        // sw aborted by reset while its MEM access is pending
        add(1, 6'd43, 6'd0, 0, 1, exp_fetch(1));
        add(1, 6'd43, 6'd0, 0, 1, exp_decode(0));
        add(1, 6'd43, 6'd0, 0, 1, exp_exec(1, 2'd2, 4'd0, 0, 2'd0));
        add(1, 6'd43, 6'd0, 0, 0, exp_mem(1));
        add(0, 6'd43, 6'd0, 0, 0, exp_zero());
        add(1, 6'd43, 6'd0, 0, 0, exp_fetch(0));
        add(1, 6'd43, 6'd0, 0, 1, exp_fetch(1));

        reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n   = vecs[i].rst_n;
            op        = vecs[i].op;
            funct     = vecs[i].funct;
            zero      = vecs[i].zero;
            mem_ready = vecs[i].rdy;
            #3;
            check_out($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clock); #1;
        end

        measure("lat_add",  6'd0,  6'd32, 4);
        measure("lat_addi", 6'd8,  6'd0,  4);
        measure("lat_lw",   6'd35, 6'd0,  5);
        measure("lat_sw",   6'd43, 6'd0,  4);
        measure("lat_beq",  6'd4,  6'd0,  3);
        measure("lat_j",    6'd2,  6'd0,  3);
        measure("lat_ill",  6'd63, 6'd0,  2);

`ifdef MIPS_CTRL_PERF_EN
        // Back-to-back adds: 4 cycles each, so after 16 cycles instr_count = 4 and cycle_count wraps to 0.
        reset_n = 1'b0; op = 6'd0; funct = 6'd32; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clock); #1;
        check_int("perf_cyc_rst", int'(cycle_count), 0);
        check_int("perf_ins_rst", int'(instr_count), 0);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock); #1;
            if (k == 4)  check_int("perf_ins_4", int'(instr_count), 1);
            if (k == 15) check_int("perf_cyc_15", int'(cycle_count), 15);
            if (k == 16) begin
                check_int("perf_cyc_wrap", int'(cycle_count), 0);
                check_int("perf_ins_16", int'(instr_count), 4);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
